// File: rtl/writeback_unit_pkg.sv
// Shared CPU types for the writeback stage: register/data widths, the write
// request record and the per-cycle writer selection.
package writeback_unit_pkg;

    localparam int REG_W    = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_W;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        reg_idx_t dst;
        data_t    data;
        logic     high;
        logic     low;
    } wb_req_t;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_ALU,
        SEL_FIFO
    } wb_sel_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle of ALU, load-return, issue and register-file write signals around the
// writeback stage; slave is the writeback unit, master is its environment.
interface writeback_unit_if;
    import writeback_unit_pkg::*;

    logic                alu_valid;
    reg_idx_t            alu_dst;
    data_t               alu_data;
    logic                alu_high;
    logic                alu_low;
    logic                alu_stall;

    logic                mem_valid;
    reg_idx_t            mem_dst;
    data_t               mem_data;
    logic                mem_ready;

    logic                issue_valid;
    reg_idx_t            issue_dst;
    logic [NUM_REGS-1:0] pending;

    logic                wr;
    reg_idx_t            wr_dst;
    data_t               wr_data;
    logic                high;
    logic                low;

    modport master (
        output alu_valid, alu_dst, alu_data, alu_high, alu_low,
        output mem_valid, mem_dst, mem_data,
        output issue_valid, issue_dst,
        input  alu_stall, mem_ready, pending,
        input  wr, wr_dst, wr_data, high, low
    );

    modport slave (
        input  alu_valid, alu_dst, alu_data, alu_high, alu_low,
        input  mem_valid, mem_dst, mem_data,
        input  issue_valid, issue_dst,
        output alu_stall, mem_ready, pending,
        output wr, wr_dst, wr_data, high, low
    );

endinterface

// File: rtl/writeback_unit_fifo2.sv
// Two-entry load-return buffer; the caller only pushes when not full and only
// pops when not empty.
module wb_fifo2
    import writeback_unit_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    wb_req_t    slots [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push)
            slots[wr_ptr] <= push_data;
    end

    assign head  = slots[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter: merges ALU results and buffered load returns onto one
// register-file write port and tracks registers with outstanding loads.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             rst,
    writeback_unit_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

    wb_req_t             fifo_head;
    wb_req_t             fifo_in;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                starve;
    wb_sel_e             sel;
    logic [CNT_W-1:0]    starve_cnt;
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_next;
    logic                wr_q;
    reg_idx_t            wr_dst_q;
    data_t               wr_data_q;
    logic                high_q;
    logic                low_q;

    assign fifo_in = '{dst: bus.mem_dst, data: bus.mem_data, high: 1'b0, low: 1'b0};
    assign fifo_push = bus.mem_valid && !fifo_full;
    assign fifo_pop  = (sel == SEL_FIFO);

    wb_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A load that has waited STARVE_LIMIT cycles takes the port from the ALU.
    assign starve = !fifo_empty && (starve_cnt == CNT_W'(STARVE_LIMIT));

    always_comb begin
        sel = SEL_IDLE;
        if (starve)
            sel = SEL_FIFO;
        else if (bus.alu_valid)
            sel = SEL_ALU;
        else if (!fifo_empty)
            sel = SEL_FIFO;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (fifo_pop || fifo_empty)
            starve_cnt <= '0;
        else
            starve_cnt <= starve_cnt + CNT_W'(1);
    end

    // Clear before set so a same-cycle re-issue to the written register wins.
    always_comb begin
        pending_next = pending_q;
        if (fifo_pop)
            pending_next = pending_next & ~reg_onehot(fifo_head.dst);
        if (bus.issue_valid)
            pending_next = pending_next | reg_onehot(bus.issue_dst);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending_q <= '0;
        else
            pending_q <= pending_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            wr_dst_q  <= '0;
            wr_data_q <= '0;
            high_q    <= 1'b0;
            low_q     <= 1'b0;
        end else begin
            case (sel)
                SEL_ALU: begin
                    wr_q      <= 1'b1;
                    wr_dst_q  <= bus.alu_dst;
                    wr_data_q <= bus.alu_data;
                    high_q    <= bus.alu_high;
                    low_q     <= bus.alu_low;
                end
                SEL_FIFO: begin
                    wr_q      <= 1'b1;
                    wr_dst_q  <= fifo_head.dst;
                    wr_data_q <= fifo_head.data;
                    high_q    <= fifo_head.high;
                    low_q     <= fifo_head.low;
                end
                default: wr_q <= 1'b0;
            endcase
        end
    end

    assign bus.alu_stall = starve;
    assign bus.mem_ready = !fifo_full;
    assign bus.pending   = pending_q;
    assign bus.wr        = wr_q;
    assign bus.wr_dst    = wr_dst_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.high      = high_q;
    assign bus.low       = low_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed vector table, a mid-operation reset, then
// randomized traffic against a queue-based model of the arbitration rules.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_unit_if bus();

    writeback_unit #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        alu_valid;
        logic [3:0]  alu_dst;
        logic [31:0] alu_data;
        logic        alu_high;
        logic        alu_low;
        logic        mem_valid;
        logic [3:0]  mem_dst;
        logic [31:0] mem_data;
        logic        issue_valid;
        logic [3:0]  issue_dst;
        logic        exp_stall;
        logic        exp_ready;
        logic        exp_wr;
        logic [3:0]  exp_dst;
        logic [31:0] exp_data;
        logic        exp_high;
        logic        exp_low;
        logic [15:0] exp_pending;
    } vec_t;

    int compared = 0;
    int mismatched = 0;

    vec_t vecs [15];

    // Reference model state
    wb_req_t     q [$];
    logic [15:0] m_pend;
    int          m_starve;
    logic        m_wr;
    logic [3:0]  m_dst;
    logic [31:0] m_data;
    logic        m_high;
    logic        m_low;

    function automatic vec_t mk(
        input logic av, input logic [3:0] ad, input logic [31:0] adata,
        input logic ah, input logic al,
        input logic mv, input logic [3:0] md, input logic [31:0] mdata,
        input logic iv, input logic [3:0] id,
        input logic es, input logic er, input logic ew, input logic [3:0] edst,
        input logic [31:0] edata, input logic eh, input logic el,
        input logic [15:0] ep);
        vec_t v;
        v.alu_valid = av; v.alu_dst = ad; v.alu_data = adata;
        v.alu_high = ah; v.alu_low = al;
        v.mem_valid = mv; v.mem_dst = md; v.mem_data = mdata;
        v.issue_valid = iv; v.issue_dst = id;
        v.exp_stall = es; v.exp_ready = er; v.exp_wr = ew;
        v.exp_dst = edst; v.exp_data = edata; v.exp_high = eh; v.exp_low = el;
        v.exp_pending = ep;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.alu_valid   = v.alu_valid;
        bus.alu_dst     = v.alu_dst;
        bus.alu_data    = v.alu_data;
        bus.alu_high    = v.alu_high;
        bus.alu_low     = v.alu_low;
        bus.mem_valid   = v.mem_valid;
        bus.mem_dst     = v.mem_dst;
        bus.mem_data    = v.mem_data;
        bus.issue_valid = v.issue_valid;
        bus.issue_dst   = v.issue_dst;
    endtask

    task automatic driveIdle();
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic doReset();
        driveIdle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_pend = '0; m_starve = 0;
        m_wr = 0; m_dst = '0; m_data = '0; m_high = 0; m_low = 0;
    endtask

    // Model of one cycle from the current inputs: who writes, what pends, what queues.
    task automatic modelStep(output logic e_stall, output logic e_ready);
        int n;
        logic override_hit;
        logic popped;
        wb_req_t r;
        n = q.size();
        override_hit = (n > 0) && (m_starve == LIMIT);
        e_stall = override_hit;
        e_ready = (n < 2);
        popped = 0;
        if (override_hit || (!bus.alu_valid && n > 0)) begin
            r = q.pop_front();
            m_wr = 1; m_dst = r.dst; m_data = r.data; m_high = 0; m_low = 0;
            m_pend[r.dst] = 1'b0;
            popped = 1;
        end else if (bus.alu_valid) begin
            m_wr = 1; m_dst = bus.alu_dst; m_data = bus.alu_data;
            m_high = bus.alu_high; m_low = bus.alu_low;
        end else begin
            m_wr = 0;
        end
        m_starve = popped ? 0 : ((n > 0) ? m_starve + 1 : 0);
        if (bus.issue_valid)
            m_pend[bus.issue_dst] = 1'b1;
        if (bus.mem_valid && n < 2)
            q.push_back('{dst: bus.mem_dst, data: bus.mem_data, high: 1'b0, low: 1'b0});
    endtask

    initial begin
        logic e_stall, e_ready;
        logic [3:0] rd;

        vecs[0]  = mk(1, 3, 'h1234, 0, 1,  0, 0, 0,        1, 5,  0, 1,  1, 3, 'h1234, 0, 1, 'h0020);
        vecs[1]  = mk(1, 2, 'hAAAA, 1, 0,  1, 5, 'hBEEF,   0, 0,  0, 1,  1, 2, 'hAAAA, 1, 0, 'h0020);
        vecs[2]  = mk(0, 0, 0, 0, 0,       0, 0, 0,        0, 0,  0, 1,  1, 5, 'hBEEF, 0, 0, 'h0000);
        vecs[3]  = mk(0, 0, 0, 0, 0,       1, 7, 'h7777,   1, 7,  0, 1,  0, 5, 'hBEEF, 0, 0, 'h0080);
        vecs[4]  = mk(0, 0, 0, 0, 0,       0, 0, 0,        1, 7,  0, 1,  1, 7, 'h7777, 0, 0, 'h0080);
        vecs[5]  = mk(1, 1, 'h11, 0, 0,    1, 8, 'h8888,   1, 8,  0, 1,  1, 1, 'h11, 0, 0, 'h0180);
        vecs[6]  = mk(1, 1, 'h12, 0, 0,    1, 9, 'h9999,   1, 9,  0, 1,  1, 1, 'h12, 0, 0, 'h0380);
        vecs[7]  = mk(1, 1, 'h13, 0, 0,    1, 10, 'hAAAA0, 0, 0,  0, 0,  1, 1, 'h13, 0, 0, 'h0380);
        vecs[8]  = mk(1, 1, 'h14, 0, 0,    1, 10, 'hAAAA0, 0, 0,  0, 0,  1, 1, 'h14, 0, 0, 'h0380);
        vecs[9]  = mk(1, 1, 'h15, 0, 0,    1, 10, 'hAAAA0, 0, 0,  0, 0,  1, 1, 'h15, 0, 0, 'h0380);
        vecs[10] = mk(1, 1, 'h16, 0, 0,    1, 10, 'hAAAA0, 0, 0,  1, 0,  1, 8, 'h8888, 0, 0, 'h0280);
        vecs[11] = mk(1, 1, 'h16, 0, 0,    1, 10, 'hAAAA0, 0, 0,  0, 1,  1, 1, 'h16, 0, 0, 'h0280);
        vecs[12] = mk(0, 0, 0, 0, 0,       0, 0, 0,        0, 0,  0, 0,  1, 9, 'h9999, 0, 0, 'h0080);
        vecs[13] = mk(0, 0, 0, 0, 0,       0, 0, 0,        0, 0,  0, 1,  1, 10, 'hAAAA0, 0, 0, 'h0080);
        vecs[14] = mk(1, 4, 'h44, 0, 0,    1, 11, 'hDEAD,  0, 0,  0, 1,  1, 4, 'h44, 0, 0, 'h0080);

        doReset();
        checkOutput("reset wr", 32'(bus.wr), 32'd0);
        checkOutput("reset wr_dst", 32'(bus.wr_dst), 32'd0);
        checkOutput("reset wr_data", bus.wr_data, 32'd0);
        checkOutput("reset pending", 32'(bus.pending), 32'd0);
        checkOutput("reset mem_ready", 32'(bus.mem_ready), 32'd1);
        checkOutput("reset alu_stall", 32'(bus.alu_stall), 32'd0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("row%0d alu_stall", i), 32'(bus.alu_stall), 32'(vecs[i].exp_stall));
            checkOutput($sformatf("row%0d mem_ready", i), 32'(bus.mem_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            checkOutput($sformatf("row%0d wr", i), 32'(bus.wr), 32'(vecs[i].exp_wr));
            checkOutput($sformatf("row%0d wr_dst", i), 32'(bus.wr_dst), 32'(vecs[i].exp_dst));
            checkOutput($sformatf("row%0d wr_data", i), bus.wr_data, vecs[i].exp_data);
            checkOutput($sformatf("row%0d high", i), 32'(bus.high), 32'(vecs[i].exp_high));
            checkOutput($sformatf("row%0d low", i), 32'(bus.low), 32'(vecs[i].exp_low));
            checkOutput($sformatf("row%0d pending", i), 32'(bus.pending), 32'(vecs[i].exp_pending));
        end

        // Mid-operation reset with one buffered load and pending[7] set.
        driveIdle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst wr", 32'(bus.wr), 32'd0);
        checkOutput("midrst wr_dst", 32'(bus.wr_dst), 32'd0);
        checkOutput("midrst pending", 32'(bus.pending), 32'd0);
        checkOutput("midrst mem_ready", 32'(bus.mem_ready), 32'd1);
        checkOutput("midrst alu_stall", 32'(bus.alu_stall), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("postrst%0d wr", i), 32'(bus.wr), 32'd0);
        end

        // Randomized traffic; a stalled ALU result and a refused load are held.
        doReset();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!(e_stall && bus.alu_valid) || c == 0) begin
                bus.alu_valid = (($urandom % 4) != 0);
                bus.alu_dst   = 4'($urandom);
                bus.alu_data  = $urandom;
                bus.alu_high  = 1'($urandom);
                bus.alu_low   = 1'($urandom);
            end
            if (!(bus.mem_valid && !e_ready) || c == 0) begin
                rd = 4'($urandom);
                bus.mem_valid = (($urandom % 3) == 0);
                bus.mem_dst   = rd;
                bus.mem_data  = $urandom;
            end
            bus.issue_valid = (($urandom % 4) == 0);
            bus.issue_dst   = 4'($urandom);
            modelStep(e_stall, e_ready);
            @(negedge clk);
            checkOutput($sformatf("rnd%0d alu_stall", c), 32'(bus.alu_stall), 32'(e_stall));
            checkOutput($sformatf("rnd%0d mem_ready", c), 32'(bus.mem_ready), 32'(e_ready));
            @(posedge clk);
            #1;
            checkOutput($sformatf("rnd%0d wr", c), 32'(bus.wr), 32'(m_wr));
            checkOutput($sformatf("rnd%0d wr_dst", c), 32'(bus.wr_dst), 32'(m_dst));
            checkOutput($sformatf("rnd%0d wr_data", c), bus.wr_data, m_data);
            checkOutput($sformatf("rnd%0d high", c), 32'(bus.high), 32'(m_high));
            checkOutput($sformatf("rnd%0d low", c), 32'(bus.low), 32'(m_low));
            checkOutput($sformatf("rnd%0d pending", c), 32'(bus.pending), 32'(m_pend));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive cycles a buffered load may wait before it pre-empts the ALU.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have ports alu_valid/alu_dst/alu_data/alu_high/alu_low, input, 1/4/32/1/1, an ALU result and its half-word mode.
REQ-005 SHALL have port alu_stall, output, 1, ALU result not accepted this cycle; the producer holds it.
REQ-006 SHALL have ports mem_valid/mem_dst/mem_data, input, 1/4/32, a load return.
REQ-007 SHALL have port mem_ready, output, 1, load return accepted when high with mem_valid.
REQ-008 SHALL have ports issue_valid/issue_dst, input, 1/4, a load issued that targets issue_dst.
REQ-009 SHALL have port pending, output, 16, one bit per register with an outstanding load; decode stalls on it.
REQ-010 SHALL have ports wr/wr_dst/wr_data/high/low, output, 1/4/32/1/1, register-file write port, all registered.

Function
REQ-011 SHALL buffer load returns in a 2-entry FIFO; mem_ready = FIFO not full.
REQ-012 SHALL select one writer per cycle: starvation override (REQ-014) first, then ALU, then FIFO head, else idle.
REQ-013 SHALL drive the selected write on wr/wr_dst/wr_data/high/low on the next rising edge (1-cycle latency); a load write always drives high=0, low=0.
REQ-014 SHALL count cycles the FIFO is non-empty and not popped; at count == STARVE_LIMIT the FIFO head wins, alu_stall=1 for that cycle, count clears.
REQ-015 SHALL keep alu_stall=0 in all other cycles; an accepted ALU result is never dropped.
REQ-016 SHALL, on a simultaneous push and pop of a full FIFO, keep mem_ready=0 (push refused); on a non-full FIFO, allow both in the same cycle.
REQ-017 SHALL set pending[issue_dst] on issue_valid and clear pending[d] when a load write to d is selected; when both hit the same register in one cycle, the set wins.
REQ-018 SHALL pass ALU writes through without touching pending.
REQ-019 SHALL wrap FIFO pointers modulo 2 using a 2-bit occupancy count (0..2).
REQ-020 SHALL drive wr=0 and hold wr_dst/wr_data/high/low at their last values in idle cycles.

Reset
REQ-021 SHALL, on rst assertion and independent of clk, clear wr, high, low, wr_dst, wr_data, pending, FIFO occupancy, FIFO pointers and the starvation count to 0.
REQ-022 SHALL discard buffered loads when reset asserts mid-operation; mem_ready=1 and alu_stall=0 while reset is asserted.

Structure
REQ-023 SHALL take the shared CPU package's register-index width (4) and data width (32), and define a wb_req_t struct (dst, data, high, low) there.
REQ-024 SHALL implement the FIFO as sub-module wb_fifo2 (2-entry, push/pop/full/empty); arbitration and scoreboard stay in writeback_unit.

Verification
REQ-025 ALU only: alu_valid, alu_dst=3, alu_data=0x1234, alu_low=1 -> next edge wr=1, wr_dst=3, wr_data=0x1234, low=1, alu_stall=0.
REQ-026 Conflict: ALU (dst 2) and mem (dst 5, 0xBEEF) in the same cycle -> ALU written first, load written the next cycle, pending[5] 1->0.
REQ-027 FIFO full: 2 loads buffered, ALU busy every cycle -> mem_ready=0; a third mem_valid is refused until a pop occurs.
REQ-028 Starvation: FIFO non-empty, ALU writes 4 cycles in a row -> 5th cycle alu_stall=1 and the load is written; the held ALU result is written the next cycle.
REQ-029 Scoreboard race: issue_valid dst 7 in the same cycle as a load write to 7 -> pending[7]=1 afterwards.
REQ-030 Reset mid-operation: rst pulsed with 1 FIFO entry and pending=0x0080 -> wr=0, pending=0, mem_ready=1 immediately, with no write of the discarded load.
